instr_sequencer: RTL
====================

Name: instr_sequencer

Overview:
Top-level instruction sequencer for the simple CPU. It fetches 16-bit instruction words from synchronous instruction memory and decodes the opcode class. It then dispatches Ri/Rj to exactly one execution sub-FSM (ALU, MOV, MVI) with a start/done handshake and advances the PC. It is the only driver of the sub-FSM start lines and owns the program counter.

Parameters:
PC_WIDTH, 8, program counter / instruction address width
TIMEOUT, 15, max cycles waiting for a sub-FSM done before error (≤ 2^TO_W − 1)
TO_W, 4, timeout counter width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
run  in  1  level; 1 = execute program, 0 = stop at next instruction boundary
imem_addr  out  PC_WIDTH  instruction address (= PC)
imem_rd  out  1  instruction read strobe, one cycle
imem_data  in  16  instruction word, valid the cycle after imem_rd; [15:12] opcode, [11:6] Ri, [5:0] Rj
opcode  out  4  latched opcode to sub-FSMs
ri  out  6  latched Ri
rj  out  6  latched Rj
alu_start  out  1  one-cycle start pulse, ALU FSM
alu_done  in  1  ALU FSM done
mov_start  out  1  one-cycle start pulse, MOV FSM
mov_done  in  1  MOV FSM done
mvi_start  out  1  one-cycle start pulse, MVI FSM
mvi_done  in  1  MVI FSM done
busy  out  1  1 in every state except IDLE, HALT, ERROR
halted  out  1  1 in HALT
err  out  1  1 in ERROR
err_code  out  2  0 none, 1 illegal opcode, 2 timeout

Behaviour:
- Reset (async): state IDLE, PC=0, opcode/ri/rj=0, all start pulses 0, imem_rd=0, busy=halted=err=0, err_code=0, timeout counter=0.
- Outputs are registered (Moore). Start pulses are exactly one cycle wide.
- Opcode classes: 0000–0111 ALU; 1000 MOV; 1001 MVI; 1110 NOP; 1111 HALT; 1010–1101 illegal.
- IDLE: run=1 -> FETCH; else stay.
- FETCH: imem_rd=1, imem_addr=PC -> LATCH.
- LATCH: capture imem_data into opcode/ri/rj -> DECODE.
- DECODE: ALU/MOV/MVI -> DISPATCH; NOP -> ADVANCE; HALT -> HALT (PC not incremented); illegal -> ERROR with err_code=1 (PC holds the faulting address).
- DISPATCH: assert the selected *_start for one cycle, clear timeout counter -> WAIT.
- WAIT: only the dispatched unit's done is honoured; done from other units is ignored. Done is accepted at any cycle ≥1 after the start pulse. Done=1 -> ADVANCE. Otherwise increment the counter; counter == TIMEOUT without done -> ERROR, err_code=2. opcode/ri/rj hold stable throughout WAIT.
- ADVANCE: PC <= PC+1 modulo 2^PC_WIDTH (all-ones wraps to 0). Then run=1 -> FETCH, run=0 -> IDLE.
- run deassertion mid-instruction does not abort: the current instruction completes, then the sequencer stops at ADVANCE.
- HALT, ERROR: sticky; exit only via reset. run is ignored.
- Same-cycle done and timeout expiry: done wins (ADVANCE).
- Reset mid-WAIT: immediate IDLE; start lines low. Sub-FSMs are reset by the same reset.
- Fetch-to-dispatch latency: FETCH→LATCH→DECODE→DISPATCH, so start is asserted 3 cycles after imem_rd.

Decomposition:
- Shared package cpu_pkg: opcode encodings (OP_MOV=4'b1000, OP_MVI=4'b1001, OP_NOP=4'b1110, OP_HALT=4'b1111, ALU range 0–7), instruction field bit positions, err_code constants, state encoding.
- Sub-module instr_decode: combinational opcode → {unit select one-hot [2:0], is_nop, is_halt, is_illegal}. It is shared with a future disassembler/trace monitor.
- The sequencer FSM, PC and timeout counter stay in instr_sequencer.

Test Plan:
- Reset, run=1, imem[0]=16'h7046 (ALU, Ri=1, Rj=6), alu_done pulsed 5 cycles after alu_start -> imem_rd at cycle 1; alu_start exactly 1 cycle at cycle 4 with ri=1, rj=6; PC=1 after ADVANCE; next FETCH of addr 1.
- Program {0x8042 MOV, 0x9000 MVI, 0xE000 NOP, 0xF000 HALT} with done after 2 cycles -> one mov_start, then one mvi_start, no start for NOP; halted=1, PC=3, busy=0; run toggling afterwards has no effect.
- imem[0]=0xA000 -> err=1, err_code=1, PC=0, no start pulse issued.
- ALU dispatched, alu_done never asserted, mov_done pulsed during WAIT -> mov_done ignored; ERROR, err_code=2 exactly TIMEOUT(15) cycles after entering WAIT.
- PC_WIDTH=8, PC preset via NOP stream to 255 -> after the NOP at 255, next imem_addr=0.
- run dropped during WAIT -> instruction completes, PC increments, IDLE, busy=0; reset asserted mid-WAIT -> all outputs at reset values in the same cycle.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction format, opcode classes, sequencer states
// and error codes used by the sequencer and the decoder.
package cpu_pkg;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned OPC_W   = 4;
  localparam int unsigned REG_W   = 6;
  localparam int unsigned ERR_W   = 2;
  localparam int unsigned UNIT_W  = 3;

  // One-hot unit select bit positions
  localparam int unsigned UNIT_ALU = 0;
  localparam int unsigned UNIT_MOV = 1;
  localparam int unsigned UNIT_MVI = 2;

  localparam logic [OPC_W-1:0] OP_ALU_MAX = 4'b0111;
  localparam logic [OPC_W-1:0] OP_MOV     = 4'b1000;
  localparam logic [OPC_W-1:0] OP_MVI     = 4'b1001;
  localparam logic [OPC_W-1:0] OP_NOP     = 4'b1110;
  localparam logic [OPC_W-1:0] OP_HALT    = 4'b1111;

  // Instruction word layout: [15:12] opcode, [11:6] Ri, [5:0] Rj
  typedef struct packed {
    logic [OPC_W-1:0] opcode;
    logic [REG_W-1:0] ri;
    logic [REG_W-1:0] rj;
  } instr_t;

  typedef enum logic [ERR_W-1:0] {
    ERR_NONE    = 2'd0,
    ERR_ILLEGAL = 2'd1,
    ERR_TIMEOUT = 2'd2
  } err_code_e;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_FETCH    = 4'd1,
    ST_LATCH    = 4'd2,
    ST_DECODE   = 4'd3,
    ST_DISPATCH = 4'd4,
    ST_WAIT     = 4'd5,
    ST_ADVANCE  = 4'd6,
    ST_HALT     = 4'd7,
    ST_ERROR    = 4'd8
  } seq_state_e;

endpackage

// File: rtl/instr_sequencer_if.sv
// Sequencer bundle: run control, instruction memory port, execution-unit
// start/done handshakes and status.
interface instr_sequencer_if #(
  parameter int unsigned PC_WIDTH = 8
);
  import cpu_pkg::*;

  logic                run;
  logic [PC_WIDTH-1:0] imem_addr;
  logic                imem_rd;
  logic [INSTR_W-1:0]  imem_data;
  logic [OPC_W-1:0]    opcode;
  logic [REG_W-1:0]    ri;
  logic [REG_W-1:0]    rj;
  logic                alu_start;
  logic                alu_done;
  logic                mov_start;
  logic                mov_done;
  logic                mvi_start;
  logic                mvi_done;
  logic                busy;
  logic                halted;
  logic                err;
  logic [ERR_W-1:0]    err_code;

  modport master (
    input  run, imem_data, alu_done, mov_done, mvi_done,
    output imem_addr, imem_rd, opcode, ri, rj,
           alu_start, mov_start, mvi_start, busy, halted, err, err_code
  );

  modport slave (
    output run, imem_data, alu_done, mov_done, mvi_done,
    input  imem_addr, imem_rd, opcode, ri, rj,
           alu_start, mov_start, mvi_start, busy, halted, err, err_code
  );

endinterface

// File: rtl/instr_decode.sv
// Combinational opcode classifier; also intended for a disassembler/trace
// monitor, so it carries no state.
module instr_decode
  import cpu_pkg::*;
(
  input  logic [OPC_W-1:0]  opcode,
  output logic [UNIT_W-1:0] unit_sel_c,
  output logic              is_nop_c,
  output logic              is_halt_c,
  output logic              is_illegal_c
);

  always_comb begin
    unit_sel_c   = '0;
    is_nop_c     = 1'b0;
    is_halt_c    = 1'b0;
    is_illegal_c = 1'b0;
    if (opcode <= OP_ALU_MAX) begin
      unit_sel_c[UNIT_ALU] = 1'b1;
    end else begin
      case (opcode)
        OP_MOV:  unit_sel_c[UNIT_MOV] = 1'b1;
        OP_MVI:  unit_sel_c[UNIT_MVI] = 1'b1;
        OP_NOP:  is_nop_c             = 1'b1;
        OP_HALT: is_halt_c            = 1'b1;
        default: is_illegal_c         = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/instr_sequencer.sv
// Instruction sequencer: fetch/latch/decode, single-unit dispatch with done
// timeout, PC ownership. All outputs are registered from the next state.
module instr_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned PC_WIDTH = 8,
  parameter int unsigned TIMEOUT  = 15,
  parameter int unsigned TO_W     = 4
) (
  input  logic               clk,
  input  logic               reset,
  instr_sequencer_if.master  bus
);

  seq_state_e          state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [TO_W-1:0]     cnt_q, cnt_d;
  instr_t              instr_q, instr_d;
  logic [UNIT_W-1:0]   start_q, start_d;
  logic                imem_rd_q, imem_rd_d;
  logic                busy_q, busy_d;
  logic                halted_q, halted_d;
  logic                err_q, err_d;
  err_code_e           err_code_q, err_code_d;

  logic [UNIT_W-1:0]   unit_sel_c;
  logic                is_nop_c;
  logic                is_halt_c;
  logic                is_illegal_c;
  logic                done_c;

  instr_decode u_decode (
    .opcode       (instr_q.opcode),
    .unit_sel_c   (unit_sel_c),
    .is_nop_c     (is_nop_c),
    .is_halt_c    (is_halt_c),
    .is_illegal_c (is_illegal_c)
  );

  // Latched opcode keeps the select stable, so only the dispatched unit's done counts
  assign done_c = |(unit_sel_c & {bus.mvi_done, bus.mov_done, bus.alu_done});

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    cnt_d      = cnt_q;
    instr_d    = instr_q;
    err_code_d = err_code_q;

    case (state_q)
      ST_IDLE:     if (bus.run) state_d = ST_FETCH;
      ST_FETCH:    state_d = ST_LATCH;
      ST_LATCH: begin
        instr_d = instr_t'(bus.imem_data);
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        if (is_illegal_c) begin
          state_d    = ST_ERROR;
          err_code_d = ERR_ILLEGAL;
        end else if (is_halt_c) begin
          state_d = ST_HALT;
        end else if (is_nop_c) begin
          state_d = ST_ADVANCE;
        end else begin
          state_d = ST_DISPATCH;
        end
      end
      ST_DISPATCH: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      // Done is checked before expiry so a same-cycle done still advances
      ST_WAIT: begin
        if (done_c) begin
          state_d = ST_ADVANCE;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
          if (cnt_d == TO_W'(TIMEOUT)) begin
            state_d    = ST_ERROR;
            err_code_d = ERR_TIMEOUT;
          end
        end
      end
      ST_ADVANCE: begin
        pc_d    = pc_q + PC_WIDTH'(1);
        state_d = bus.run ? ST_FETCH : ST_IDLE;
      end
      ST_HALT:     state_d = ST_HALT;
      ST_ERROR:    state_d = ST_ERROR;
      default:     state_d = ST_IDLE;
    endcase

    imem_rd_d = (state_d == ST_FETCH);
    start_d   = (state_d == ST_DISPATCH) ? unit_sel_c : '0;
    busy_d    = !(state_d inside {ST_IDLE, ST_HALT, ST_ERROR});
    halted_d  = (state_d == ST_HALT);
    err_d     = (state_d == ST_ERROR);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      pc_q       <= '0;
      cnt_q      <= '0;
      instr_q    <= '0;
      start_q    <= '0;
      imem_rd_q  <= 1'b0;
      busy_q     <= 1'b0;
      halted_q   <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      cnt_q      <= cnt_d;
      instr_q    <= instr_d;
      start_q    <= start_d;
      imem_rd_q  <= imem_rd_d;
      busy_q     <= busy_d;
      halted_q   <= halted_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  assign bus.imem_addr = pc_q;
  assign bus.imem_rd   = imem_rd_q;
  assign bus.opcode    = instr_q.opcode;
  assign bus.ri        = instr_q.ri;
  assign bus.rj        = instr_q.rj;
  assign bus.alu_start = start_q[UNIT_ALU];
  assign bus.mov_start = start_q[UNIT_MOV];
  assign bus.mvi_start = start_q[UNIT_MVI];
  assign bus.busy      = busy_q;
  assign bus.halted    = halted_q;
  assign bus.err       = err_q;
  assign bus.err_code  = err_code_q;

endmodule
